// File: rtl/stopwatch_input_ctrl_pkg.sv
// Shared types and constants for the stopwatch input controller:
// FSM state encoding, BCD digit limits and the centisecond BCD increment.
package stopwatch_input_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } sw_state_e;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic [3:0] cs_tens;
    logic [3:0] cs_units;
  } bcd_time_t;

  // Ripple-carry BCD increment; 59.99 wraps silently to 00.00.
  function automatic bcd_time_t bcd_increment(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.cs_units != DIGIT_MAX) begin
      r.cs_units = t.cs_units + 4'd1;
    end else begin
      r.cs_units = 4'd0;
      if (t.cs_tens != DIGIT_MAX) begin
        r.cs_tens = t.cs_tens + 4'd1;
      end else begin
        r.cs_tens = 4'd0;
        if (t.sec_units != DIGIT_MAX) begin
          r.sec_units = t.sec_units + 4'd1;
        end else begin
          r.sec_units = 4'd0;
          r.sec_tens  = (t.sec_tens == SEC_TENS_MAX) ? 4'd0 : t.sec_tens + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_input_ctrl_debouncer.sv
// Two-flop synchroniser, stable-level debouncer and one-cycle press pulse
// for a single raw push-button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_raw,
  output logic o_press
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic        REL_LVL = BTN_ACTIVE_LOW;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_warm;
  logic             r_armed;
  logic             r_press;
  logic             w_synced;

  // Normalised so that 1 always means pressed.
  assign w_synced = r_sync2 ^ BTN_ACTIVE_LOW;
  assign o_press  = r_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= REL_LVL;
      r_sync2  <= REL_LVL;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_warm   <= 2'b00;
      r_armed  <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
      r_press <= 1'b0;
      // Arm only once a genuine (not reset-filled) released level is seen,
      // so a button held through reset needs release and re-press.
      if (r_warm[1] && !w_synced) begin
        r_armed <= 1'b1;
      end
      if (w_synced != r_stable) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= w_synced;
          r_cnt    <= '0;
          r_press  <= w_synced && r_armed;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch input side: debounced start/stop and lap/reset buttons driving
// the run/stop/lap FSM, the centisecond prescaler and the SS.cc BCD count.
module stopwatch_input_ctrl
  import stopwatch_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 500_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss_raw,
  input  logic        btn_lr_raw,
  output logic [15:0] bcd_time,
  output logic        running,
  output logic        lap_active,
  output logic [1:0]  state
);

  localparam int unsigned PRE_W = $clog2(TICK_CYCLES + 1);

  logic [1:0]       w_raw;
  logic [1:0]       w_press;
  logic             w_ss;
  logic             w_lr;
  sw_state_e        r_state;
  sw_state_e        w_state_next;
  logic [PRE_W-1:0] r_pre;
  bcd_time_t        r_count;
  bcd_time_t        r_lap;
  logic             w_counting;
  logic             w_tick;
  logic             w_clear;

  assign w_raw = {btn_lr_raw, btn_ss_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
      ) u_debouncer (
        .clk      (clk),
        .rst      (rst),
        .i_btn_raw(w_raw[gi]),
        .o_press  (w_press[gi])
      );
    end
  endgenerate

  assign w_ss = w_press[0];
  assign w_lr = w_press[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Start/stop takes priority when both events land in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_ss) w_state_next = RUN;
      RUN:  if (w_ss) w_state_next = STOP; else if (w_lr) w_state_next = LAP;
      LAP:  if (w_ss) w_state_next = STOP; else if (w_lr) w_state_next = RUN;
      STOP: if (w_ss) w_state_next = RUN;  else if (w_lr) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    running    = (r_state == RUN) || (r_state == LAP);
    lap_active = (r_state == LAP);
    state      = r_state;
    bcd_time   = (r_state == LAP) ? r_lap : r_count;
  end

  assign w_counting = (r_state == RUN) || (r_state == LAP);
  assign w_tick     = w_counting && (r_pre == PRE_W'(TICK_CYCLES - 1));
  assign w_clear    = (r_state == STOP) && (w_state_next == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre   <= '0;
      r_count <= '0;
      r_lap   <= '0;
    end else begin
      if (w_clear || r_state == IDLE) begin
        r_pre <= '0;
      end else if (w_counting) begin
        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      end
      if (w_clear) begin
        r_count <= '0;
      end else if (w_tick) begin
        r_count <= bcd_increment(r_count);
      end
      // Lap latch samples the pre-edge count on the RUN->LAP transition.
      if (r_state == RUN && w_state_next == LAP) begin
        r_lap <= r_count;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Self-checking bench for stopwatch_input_ctrl with a centisecond-integer
// reference model and randomised button bounce.
module tb_stopwatch_input_ctrl;

  localparam int D = 4;
  localparam int T = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_ss_raw = 1'b1;
  logic        btn_lr_raw = 1'b1;
  logic [15:0] bcd_time;
  logic        running;
  logic        lap_active;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: time held as an integer number of centiseconds.
  int m_st, m_pre, m_cnt, m_lap;
  int m_stable[2], m_run[2], m_armed[2], m_ev[2];
  int m_q[2][2];

  stopwatch_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (T),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_ss_raw(btn_ss_raw),
    .btn_lr_raw(btn_lr_raw),
    .bcd_time  (bcd_time),
    .running   (running),
    .lap_active(lap_active),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [15:0] exp_disp();
    return to_bcd((m_st == 3) ? m_lap : m_cnt);
  endfunction

  task automatic model_reset();
    m_st = 0; m_pre = 0; m_cnt = 0; m_lap = 0;
    for (int b = 0; b < 2; b++) begin
      m_stable[b] = 0; m_run[b] = 0; m_armed[b] = 0; m_ev[b] = 0;
      m_q[b][0] = 2; m_q[b][1] = 2;   // 2 marks a reset-filled sync stage
    end
  endtask

  task automatic step();
    int sp[2];
    int ns, tick, syn, real_s;
    @(posedge clk);
    sp[0] = !btn_ss_raw;
    sp[1] = !btn_lr_raw;
    if (!rst) begin
      model_reset();
    end else begin
      ns = m_st;
      case (m_st)
        0: if (m_ev[0] == 1) ns = 1;
        1: if (m_ev[0] == 1) ns = 2; else if (m_ev[1] == 1) ns = 3;
        3: if (m_ev[0] == 1) ns = 2; else if (m_ev[1] == 1) ns = 1;
        default: if (m_ev[0] == 1) ns = 1; else if (m_ev[1] == 1) ns = 0;
      endcase
      tick = ((m_st == 1 || m_st == 3) && m_pre == T - 1) ? 1 : 0;
      if (m_st == 1 || m_st == 3) m_pre = (tick == 1) ? 0 : m_pre + 1;
      else if (m_st == 0) m_pre = 0;
      if (m_st == 1 && ns == 3) m_lap = m_cnt;
      if (m_st == 2 && ns == 0) begin
        m_cnt = 0; m_pre = 0;
      end else if (tick == 1) begin
        m_cnt = (m_cnt + 1) % 6000;
      end
      m_st = ns;
      for (int b = 0; b < 2; b++) begin
        syn = m_q[b][1];
        real_s = (syn != 2) ? 1 : 0;
        if (real_s == 0) syn = 0;
        m_ev[b] = 0;
        if (syn != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_stable[b] = syn;
            m_run[b] = 0;
            if (syn == 1 && m_armed[b] == 1) m_ev[b] = 1;
          end
        end else begin
          m_run[b] = 0;
        end
        if (real_s == 1 && syn == 0) m_armed[b] = 1;
        m_q[b][1] = m_q[b][0];
        m_q[b][0] = sp[b];
      end
    end
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_btn(input int b, input int pressed);
    if (b == 0) btn_ss_raw = (pressed == 0);
    else        btn_lr_raw = (pressed == 0);
  endtask

  // Bounce, press, hold, bounce on release, then let the release settle.
  task automatic tap(input int b, input int bounces, input int hold);
    for (int i = 0; i < bounces; i++) begin
      set_btn(b, 1); steps($urandom_range(1, 3));
      set_btn(b, 0); steps($urandom_range(1, 3));
    end
    set_btn(b, 1); steps(hold);
    for (int i = 0; i < bounces; i++) begin
      set_btn(b, 0); steps($urandom_range(1, 3));
      set_btn(b, 1); steps($urandom_range(1, 3));
    end
    set_btn(b, 0); steps(D + 4);
  endtask

  task automatic go_idle();
    tap(0, 0, 10);
    tap(1, 0, 10);
  endtask

  task automatic test_reset();
    model_reset();
    steps(3);
    vectors++;
    if (bcd_time !== 16'h0000 || state !== 2'd0 || running !== 1'b0 || lap_active !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h/%0d/%b/%b want 0000/0/0/0", bcd_time, state, running, lap_active);
    end
    rst = 1'b1;
    steps(50);
    vectors++;
    if (bcd_time !== 16'h0000 || state !== 2'd0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_50: got %h/%0d/%b want 0000/0/0", bcd_time, state, running);
    end
    tap(1, $urandom_range(0, 3), 10);
    vectors++;
    if (bcd_time !== 16'h0000 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL idle_lr: got %h/%0d want 0000/0", bcd_time, state);
    end
  endtask

  task automatic test_start_bounce();
    int r;
    for (int i = 0; i < 2; i++) begin
      set_btn(0, 1); steps(3);
      set_btn(0, 0); steps(3);
    end
    set_btn(0, 1);
    steps(6);
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("FAIL start_early: state=%0d want 0", state);
    end
    step();
    r = cyc;
    vectors++;
    if (state !== 2'd1 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL start_run: state=%0d running=%b want 1/1", state, running);
    end
    steps(30);
    for (int i = 0; i < 2; i++) begin
      set_btn(0, 0); steps(2);
      set_btn(0, 1); steps(2);
    end
    set_btn(0, 0);
    steps(10);
    vectors++;
    if (state !== 2'd1) begin
      miscompares++;
      $display("FAIL start_single_event: state=%0d want 1", state);
    end
    while (cyc < r + 5 * 123) step();
    vectors++;
    if (bcd_time !== 16'h0123 || bcd_time !== exp_disp()) begin
      miscompares++;
      $display("FAIL start_count: bcd_time=%h want 0123 (model %h)", bcd_time, exp_disp());
    end
  endtask

  task automatic test_lap();
    int r;
    go_idle();
    set_btn(0, 1);
    steps(7);
    r = cyc;
    steps(10);
    set_btn(0, 0);
    while (cyc < r + 205) step();
    set_btn(1, 1);
    steps(7);
    vectors++;
    if (state !== 2'd3 || bcd_time !== 16'h0042) begin
      miscompares++;
      $display("FAIL lap_enter: state=%0d bcd=%h want 3/0042", state, bcd_time);
    end
    steps(3);
    set_btn(1, 0);
    steps(40);
    vectors++;
    if (bcd_time !== 16'h0042 || lap_active !== 1'b1 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL lap_frozen: bcd=%h lap=%b run=%b want 0042/1/1", bcd_time, lap_active, running);
    end
    set_btn(1, 1);
    steps(7);
    vectors++;
    if (state !== 2'd1 || bcd_time !== exp_disp() || bcd_time <= 16'h0042) begin
      miscompares++;
      $display("FAIL lap_release: state=%0d bcd=%h want 1/%h", state, bcd_time, exp_disp());
    end
    set_btn(1, 0);
    steps(10);
  endtask

  task automatic test_wrap();
    int r, over;
    over = 0;
    go_idle();
    set_btn(0, 1);
    steps(7);
    r = cyc;
    steps(10);
    set_btn(0, 0);
    while (cyc < r + 5 * 5998) begin
      step();
      if (bcd_time[15:12] > 4'd5 || bcd_time[11:8] > 4'd9 || bcd_time[7:4] > 4'd9 || bcd_time[3:0] > 4'd9)
        over = 1;
    end
    vectors++;
    if (bcd_time !== 16'h5998) begin
      miscompares++;
      $display("FAIL wrap_preload: bcd=%h want 5998", bcd_time);
    end
    steps(5);
    vectors++;
    if (bcd_time !== 16'h5999) begin
      miscompares++;
      $display("FAIL wrap_5999: bcd=%h want 5999", bcd_time);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (bcd_time[15:12] > 4'd5) over = 1;
    end
    vectors++;
    if (bcd_time !== 16'h0000 || state !== 2'd1) begin
      miscompares++;
      $display("FAIL wrap_zero: bcd=%h state=%0d want 0000/1", bcd_time, state);
    end
    vectors++;
    if (over !== 0) begin
      miscompares++;
      $display("FAIL wrap_digit_range: out-of-range digit seen=%0d want 0", over);
    end
  endtask

  task automatic test_stop();
    int r;
    go_idle();
    set_btn(0, 1);
    steps(7);
    r = cyc;
    steps(10);
    set_btn(0, 0);
    while (cyc < r + 1545) step();
    set_btn(0, 1);
    steps(7);
    vectors++;
    if (state !== 2'd2 || bcd_time !== 16'h0310) begin
      miscompares++;
      $display("FAIL stop_enter: state=%0d bcd=%h want 2/0310", state, bcd_time);
    end
    steps(5);
    set_btn(0, 0);
    steps(100);
    vectors++;
    if (bcd_time !== 16'h0310 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_hold: bcd=%h running=%b want 0310/0", bcd_time, running);
    end
    set_btn(0, 1);
    steps(7);
    vectors++;
    if (state !== 2'd1 || bcd_time !== 16'h0310) begin
      miscompares++;
      $display("FAIL stop_resume: state=%0d bcd=%h want 1/0310", state, bcd_time);
    end
    steps(20);
    vectors++;
    if (bcd_time !== 16'h0314 || bcd_time !== exp_disp()) begin
      miscompares++;
      $display("FAIL stop_resume_count: bcd=%h want 0314 (model %h)", bcd_time, exp_disp());
    end
    set_btn(0, 0);
    steps(10);
    go_idle();
    vectors++;
    if (state !== 2'd0 || bcd_time !== 16'h0000) begin
      miscompares++;
      $display("FAIL stop_clear: state=%0d bcd=%h want 0/0000", state, bcd_time);
    end
  endtask

  task automatic test_simultaneous();
    tap(0, 0, 10);
    steps(10);
    set_btn(0, 1);
    set_btn(1, 1);
    steps(7);
    vectors++;
    if (state !== 2'd2 || lap_active !== 1'b0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL simultaneous: state=%0d lap=%b run=%b want 2/0/0", state, lap_active, running);
    end
    set_btn(0, 0);
    set_btn(1, 0);
    steps(10);
    go_idle();
  endtask

  task automatic test_reset_mid();
    set_btn(0, 1);
    steps(3);
    rst = 1'b0;
    model_reset();
    steps(2);
    rst = 1'b1;
    steps(20);
    vectors++;
    if (state !== 2'd0 || bcd_time !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_held_btn: state=%0d bcd=%h want 0/0000", state, bcd_time);
    end
    set_btn(0, 0);
    steps(10);
    set_btn(0, 1);
    steps(7);
    vectors++;
    if (state !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_repress: state=%0d want 1", state);
    end
    set_btn(0, 0);
    steps(10);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      tap($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(8, 15));
      steps($urandom_range(0, 60));
      vectors++;
      if (bcd_time !== exp_disp() || state !== 2'(m_st) ||
          running !== (m_st == 1 || m_st == 3) || lap_active !== (m_st == 3)) begin
        miscompares++;
        $display("FAIL random_%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", it, bcd_time, state,
                 running, lap_active, exp_disp(), m_st, (m_st == 1 || m_st == 3), (m_st == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_bounce();
    test_lap();
    test_wrap();
    test_stop();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
